// File: rtl/ex_branch_resolve_pkg.sv
// ex_branch_resolve_pkg
//   Shared definitions for the branch execute slice:
//   - default operand, PC and opcode widths
//   - branch opcode encodings, identical to those used by the decoder and
//     the branch reservation station
//   - a helper that sizes FIFO pointer fields
package ex_branch_resolve_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned NEWOP_WIDTH = 6;

    // Branch opcodes as carried in the station op field.
    typedef enum logic [NEWOP_WIDTH-1:0] {
        BR_BEQ  = 6'h18,
        BR_BNE  = 6'h19,
        BR_BLT  = 6'h1C,
        BR_BGE  = 6'h1D,
        BR_BLTU = 6'h1E,
        BR_BGEU = 6'h1F
    } br_op_e;

    // Sequential instruction step in bytes.
    localparam int unsigned PC_STEP = 4;

    // Pointer width for a power-of-two queue; never narrower than 1 bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ex_branch_resolve_branch_cond_unit.sv
// branch_cond_unit
//   Purely combinational branch evaluator.
//   Ports:
//     op      in   OP_W    branch opcode
//     src1    in   DATA_W  operand 1
//     src2    in   DATA_W  operand 2
//     pc      in   ADDR_W  branch PC
//     offset  in   DATA_W  sign-extended byte offset
//     taken   out  1       condition holds (0 for unknown opcodes)
//     next_pc out  ADDR_W  target if taken, else pc + 4 (modulo 2^ADDR_W)
//     illegal out  1       opcode is not a recognised branch
module branch_cond_unit
    import ex_branch_resolve_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_WIDTH,
    parameter int unsigned ADDR_W = ADDR_WIDTH,
    parameter int unsigned OP_W   = NEWOP_WIDTH
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] offset,
    output logic              taken,
    output logic [ADDR_W-1:0] next_pc,
    output logic              illegal
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (src1 == src2);
    assign lt_s = ($signed(src1) < $signed(src2));
    assign lt_u = (src1 < src2);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_W'(BR_BEQ):  taken = eq;
            OP_W'(BR_BNE):  taken = !eq;
            OP_W'(BR_BLT):  taken = lt_s;
            OP_W'(BR_BGE):  taken = !lt_s;
            OP_W'(BR_BLTU): taken = lt_u;
            OP_W'(BR_BGEU): taken = !lt_u;
            default:        illegal = 1'b1;
        endcase
    end

    // Both sums wrap silently at 2^ADDR_W.
    always_comb begin
        if (taken) begin
            next_pc = pc + ADDR_W'(offset);
        end else begin
            next_pc = pc + ADDR_W'(PC_STEP);
        end
    end

endmodule

// File: rtl/ex_branch_resolve.sv
// ex_branch_resolve
//   Execute stage fed by the branch reservation station. Evaluates one
//   issued branch per cycle and queues {taken, next_pc} toward fetch in a
//   small circular FIFO behind a valid/ready handshake, since the station
//   cannot be back-pressured.
//   Ports:
//     clk, rst_n            clock (rising edge), async active-low reset
//     ex_branch_en          issue strobe, one pulse per branch
//     ex_src1, ex_src2      operands
//     ex_pc, ex_aluop       branch PC and opcode
//     ex_offset             sign-extended byte offset
//     flush                 empties the queue; wins over push and pop
//     redir_valid/ready     head handshake toward fetch
//     redir_taken, redir_pc head entry contents (0 when empty)
//     illegal_op            1-cycle pulse after an unknown opcode issues
//     overflow_err          sticky, an issue was dropped on a full queue
//     resolved_cnt          wrapping count of pushed branches
module ex_branch_resolve
    import ex_branch_resolve_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_WIDTH,
    parameter int unsigned ADDR_W     = ADDR_WIDTH,
    parameter int unsigned OP_W       = NEWOP_WIDTH,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_branch_en,
    input  logic [DATA_W-1:0] ex_src1,
    input  logic [DATA_W-1:0] ex_src2,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [OP_W-1:0]   ex_aluop,
    input  logic [DATA_W-1:0] ex_offset,
    input  logic              flush,
    output logic              redir_valid,
    input  logic              redir_ready,
    output logic              redir_taken,
    output logic [ADDR_W-1:0] redir_pc,
    output logic              illegal_op,
    output logic              overflow_err,
    output logic [31:0]       resolved_cnt
);

    localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic              cond_taken;
    logic [ADDR_W-1:0] cond_next_pc;
    logic              cond_illegal;

    branch_cond_unit #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .OP_W   (OP_W)
    ) u_cond (
        .op      (ex_aluop),
        .src1    (ex_src1),
        .src2    (ex_src2),
        .pc      (ex_pc),
        .offset  (ex_offset),
        .taken   (cond_taken),
        .next_pc (cond_next_pc),
        .illegal (cond_illegal)
    );

    logic              q_taken [FIFO_DEPTH];
    logic [ADDR_W-1:0] q_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic full;
    logic pop;
    logic push;
    logic drop_full;

    assign redir_valid = (count != '0);
    assign full        = (count == CNT_W'(FIFO_DEPTH));

    // Flush squashes both sides of the handshake and any concurrent issue.
    // A full queue still accepts an issue when the head leaves this cycle.
    assign pop       = redir_valid && redir_ready && !flush;
    assign push      = ex_branch_en && !flush && (!full || pop);
    assign drop_full = ex_branch_en && !flush && full && !pop;

    assign redir_taken = redir_valid ? q_taken[rd_ptr] : 1'b0;
    assign redir_pc    = redir_valid ? q_pc[rd_ptr]    : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                q_taken[i] <= 1'b0;
                q_pc[i]    <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_taken[wr_ptr] <= cond_taken;
                q_pc[wr_ptr]    <= cond_next_pc;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op   <= 1'b0;
            overflow_err <= 1'b0;
            resolved_cnt <= '0;
        end else begin
            illegal_op <= ex_branch_en && cond_illegal;
            if (drop_full) begin
                overflow_err <= 1'b1;
            end
            if (push) begin
                resolved_cnt <= resolved_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ex_branch_resolve.sv
module tb_ex_branch_resolve;
    import ex_branch_resolve_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_branch_en;
    logic [31:0] ex_src1;
    logic [31:0] ex_src2;
    logic [31:0] ex_pc;
    logic [5:0]  ex_aluop;
    logic [31:0] ex_offset;
    logic        flush;
    logic        redir_valid;
    logic        redir_ready;
    logic        redir_taken;
    logic [31:0] redir_pc;
    logic        illegal_op;
    logic        overflow_err;
    logic [31:0] resolved_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_branch_resolve #(
        .DATA_W     (32),
        .ADDR_W     (32),
        .OP_W       (6),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_branch_en (ex_branch_en),
        .ex_src1      (ex_src1),
        .ex_src2      (ex_src2),
        .ex_pc        (ex_pc),
        .ex_aluop     (ex_aluop),
        .ex_offset    (ex_offset),
        .flush        (flush),
        .redir_valid  (redir_valid),
        .redir_ready  (redir_ready),
        .redir_taken  (redir_taken),
        .redir_pc     (redir_pc),
        .illegal_op   (illegal_op),
        .overflow_err (overflow_err),
        .resolved_cnt (resolved_cnt)
    );

    // Head must not change while it is stalled by fetch.
    logic        hold_armed = 1'b0;
    logic        hold_taken;
    logic [31:0] hold_pc;
    always @(negedge clk) begin
        if (hold_armed && rst_n) begin
            checks++;
            if (redir_valid !== 1'b1 || redir_taken !== hold_taken || redir_pc !== hold_pc) begin
                failures++;
                $display("FAIL hold_stable: got v=%0b t=%0b pc=%h, want v=1 t=%0b pc=%h",
                         redir_valid, redir_taken, redir_pc, hold_taken, hold_pc);
            end
        end
        hold_armed = rst_n && redir_valid && !redir_ready && !flush;
        hold_taken = redir_taken;
        hold_pc    = redir_pc;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] pc, input logic [31:0] off);
        ex_branch_en = 1'b1;
        ex_aluop     = op;
        ex_src1      = s1;
        ex_src2      = s2;
        ex_pc        = pc;
        ex_offset    = off;
        step();
        ex_branch_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ex_branch_en = 1'b0; ex_src1 = '0; ex_src2 = '0; ex_pc = '0;
        ex_aluop = '0; ex_offset = '0; flush = 1'b0; redir_ready = 1'b0;
        step();
        step();
        checks++;
        if ({redir_valid, redir_taken, redir_pc, illegal_op, overflow_err, resolved_cnt} !== 68'd0) begin
            failures++;
            $display("FAIL reset_state: got v=%0b t=%0b pc=%h ill=%0b ovf=%0b cnt=%0d, want all 0",
                     redir_valid, redir_taken, redir_pc, illegal_op, overflow_err, resolved_cnt);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_beq();
        redir_ready = 1'b1;
        issue(6'(BR_BEQ), 32'd5, 32'd5, 32'h100, 32'h20);
        checks++;
        if (redir_valid !== 1'b1 || redir_taken !== 1'b1 || redir_pc !== 32'h120 || resolved_cnt !== 32'd1) begin
            failures++;
            $display("FAIL beq_taken: got v=%0b t=%0b pc=%h cnt=%0d, want v=1 t=1 pc=00000120 cnt=1",
                     redir_valid, redir_taken, redir_pc, resolved_cnt);
        end
        step();
        checks++;
        if (redir_valid !== 1'b0 || redir_pc !== 32'h0) begin
            failures++;
            $display("FAIL beq_drained: got v=%0b pc=%h, want v=0 pc=0", redir_valid, redir_pc);
        end
    endtask

    task automatic test_signed_unsigned();
        redir_ready = 1'b1;
        issue(6'(BR_BLT), 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
        checks++;
        if (redir_valid !== 1'b1 || redir_taken !== 1'b1 || redir_pc !== 32'h240) begin
            failures++;
            $display("FAIL blt_signed: got v=%0b t=%0b pc=%h, want v=1 t=1 pc=00000240",
                     redir_valid, redir_taken, redir_pc);
        end
        issue(6'(BR_BLTU), 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
        checks++;
        if (redir_valid !== 1'b1 || redir_taken !== 1'b0 || redir_pc !== 32'h204 || resolved_cnt !== 32'd3) begin
            failures++;
            $display("FAIL bltu_unsigned: got v=%0b t=%0b pc=%h cnt=%0d, want v=1 t=0 pc=00000204 cnt=3",
                     redir_valid, redir_taken, redir_pc, resolved_cnt);
        end
        step();
    endtask

    task automatic test_overflow();
        redir_ready = 1'b0;
        issue(6'(BR_BEQ), 32'd1, 32'd1, 32'h300, 32'h10);
        issue(6'(BR_BNE), 32'd1, 32'd1, 32'h400, 32'h10);
        checks++;
        if (overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_not_yet: got %0b, want 0", overflow_err);
        end
        issue(6'(BR_BGE), 32'd2, 32'd1, 32'h500, 32'h8);
        checks++;
        if (redir_valid !== 1'b1 || redir_taken !== 1'b1 || redir_pc !== 32'h310 ||
            overflow_err !== 1'b1 || resolved_cnt !== 32'd5) begin
            failures++;
            $display("FAIL ovf_drop: got v=%0b t=%0b pc=%h ovf=%0b cnt=%0d, want v=1 t=1 pc=00000310 ovf=1 cnt=5",
                     redir_valid, redir_taken, redir_pc, overflow_err, resolved_cnt);
        end
        redir_ready = 1'b1;
        step();
        checks++;
        if (redir_valid !== 1'b1 || redir_taken !== 1'b0 || redir_pc !== 32'h404) begin
            failures++;
            $display("FAIL ovf_second: got v=%0b t=%0b pc=%h, want v=1 t=0 pc=00000404",
                     redir_valid, redir_taken, redir_pc);
        end
        step();
        checks++;
        if (redir_valid !== 1'b0 || resolved_cnt !== 32'd5 || overflow_err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drained: got v=%0b cnt=%0d ovf=%0b, want v=0 cnt=5 ovf=1",
                     redir_valid, resolved_cnt, overflow_err);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        redir_ready = 1'b0;
        issue(6'(BR_BGEU), 32'd3, 32'd3, 32'h600, 32'h100);
        issue(6'(BR_BGEU), 32'd2, 32'd3, 32'h610, 32'h100);
        redir_ready = 1'b1;
        issue(6'(BR_BNE), 32'd1, 32'd2, 32'h620, 32'h30);
        checks++;
        if (redir_valid !== 1'b1 || redir_taken !== 1'b0 || redir_pc !== 32'h614 ||
            overflow_err !== 1'b0 || resolved_cnt !== 32'd3) begin
            failures++;
            $display("FAIL full_pushpop: got v=%0b t=%0b pc=%h ovf=%0b cnt=%0d, want v=1 t=0 pc=00000614 ovf=0 cnt=3",
                     redir_valid, redir_taken, redir_pc, overflow_err, resolved_cnt);
        end
        step();
        checks++;
        if (redir_valid !== 1'b1 || redir_taken !== 1'b1 || redir_pc !== 32'h650) begin
            failures++;
            $display("FAIL full_pushpop_tail: got v=%0b t=%0b pc=%h, want v=1 t=1 pc=00000650",
                     redir_valid, redir_taken, redir_pc);
        end
        step();
        checks++;
        if (redir_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_pushpop_empty: got v=%0b, want 0", redir_valid);
        end
    endtask

    task automatic test_wrap_illegal();
        redir_ready = 1'b1;
        issue(6'(BR_BNE), 32'd7, 32'd7, 32'hFFFF_FFFC, 32'h40);
        checks++;
        if (redir_valid !== 1'b1 || redir_taken !== 1'b0 || redir_pc !== 32'h0 || illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL pc_wrap: got v=%0b t=%0b pc=%h ill=%0b, want v=1 t=0 pc=00000000 ill=0",
                     redir_valid, redir_taken, redir_pc, illegal_op);
        end
        issue(6'h3F, 32'd0, 32'd0, 32'h800, 32'h40);
        checks++;
        if (redir_valid !== 1'b1 || redir_taken !== 1'b0 || redir_pc !== 32'h804 ||
            illegal_op !== 1'b1 || resolved_cnt !== 32'd5) begin
            failures++;
            $display("FAIL illegal_op: got v=%0b t=%0b pc=%h ill=%0b cnt=%0d, want v=1 t=0 pc=00000804 ill=1 cnt=5",
                     redir_valid, redir_taken, redir_pc, illegal_op, resolved_cnt);
        end
        step();
        checks++;
        if (illegal_op !== 1'b0 || redir_valid !== 1'b0) begin
            failures++;
            $display("FAIL illegal_pulse: got ill=%0b v=%0b, want ill=0 v=0", illegal_op, redir_valid);
        end
    endtask

    task automatic test_flush();
        redir_ready = 1'b0;
        issue(6'(BR_BEQ), 32'd0, 32'd0, 32'h900, 32'h4);
        issue(6'(BR_BLTU), 32'd1, 32'd2, 32'h910, 32'hFFFF_FFFC);
        checks++;
        if (redir_valid !== 1'b1 || redir_pc !== 32'h904 || resolved_cnt !== 32'd7) begin
            failures++;
            $display("FAIL flush_setup: got v=%0b pc=%h cnt=%0d, want v=1 pc=00000904 cnt=7",
                     redir_valid, redir_pc, resolved_cnt);
        end
        flush = 1'b1;
        issue(6'(BR_BEQ), 32'd0, 32'd0, 32'hA00, 32'h4);
        flush = 1'b0;
        checks++;
        if (redir_valid !== 1'b0 || redir_taken !== 1'b0 || redir_pc !== 32'h0 ||
            resolved_cnt !== 32'd7 || overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL flush: got v=%0b t=%0b pc=%h cnt=%0d ovf=%0b, want v=0 t=0 pc=0 cnt=7 ovf=0",
                     redir_valid, redir_taken, redir_pc, resolved_cnt, overflow_err);
        end
        // Queue restarts cleanly after the flush.
        redir_ready = 1'b1;
        issue(6'(BR_BLTU), 32'd1, 32'd2, 32'h910, 32'hFFFF_FFFC);
        checks++;
        if (redir_valid !== 1'b1 || redir_taken !== 1'b1 || redir_pc !== 32'h90C || resolved_cnt !== 32'd8) begin
            failures++;
            $display("FAIL post_flush: got v=%0b t=%0b pc=%h cnt=%0d, want v=1 t=1 pc=0000090c cnt=8",
                     redir_valid, redir_taken, redir_pc, resolved_cnt);
        end
        step();
    endtask

    task automatic test_reset_mid_drain();
        redir_ready = 1'b0;
        issue(6'(BR_BEQ), 32'd4, 32'd4, 32'hB00, 32'h10);
        issue(6'(BR_BEQ), 32'd4, 32'd4, 32'hB10, 32'h10);
        redir_ready = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (redir_valid !== 1'b0 || redir_taken !== 1'b0 || redir_pc !== 32'h0 ||
            resolved_cnt !== 32'd0 || overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_drain: got v=%0b t=%0b pc=%h cnt=%0d ovf=%0b, want all 0",
                     redir_valid, redir_taken, redir_pc, resolved_cnt, overflow_err);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (redir_valid !== 1'b0 || resolved_cnt !== 32'd0) begin
            failures++;
            $display("FAIL after_reset: got v=%0b cnt=%0d, want v=0 cnt=0", redir_valid, resolved_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_beq();
        test_signed_unsigned();
        test_overflow();
        test_full_push_pop();
        test_wrap_illegal();
        test_flush();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
